// File: rtl/joy_serial_reader.sv
// Scanner for the Neptuno DB9/JAMMA 16-bit 74HC165 joystick chain: load, shift out, deliver two active-high words.
// Optional build macro JOY_SERIAL_DEBOUNCE_EN: a frame is accepted only when it matches the previous raw frame.
module joy_serial_reader #(
  parameter int CLK_DIV   = 50,
  parameter int GAP_TICKS = 64
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       JOY_DATA,
  output logic       JOY_CLK,
  output logic       JOY_LOAD_N,
  output logic [7:0] JOY1,
  output logic [7:0] JOY2,
  output logic       FRAME_STB
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    S_GAP,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q;
  logic [GW-1:0]   gap_q, gap_d;
  logic [3:0]      bit_q, bit_d;
  logic [15:0]     sr_q, sr_d;
  logic            clk_q, clk_d;
  logic            load_n_q, load_n_d;
  logic [7:0]      joy1_q, joy1_d;
  logic [7:0]      joy2_q, joy2_d;
  logic            stb_q, stb_d;
  logic            tick;
`ifdef JOY_SERIAL_DEBOUNCE_EN
  logic [15:0]     prev_q, prev_d;
`endif

  // Chain buttons are active-low; the core wants pressed = 1.
  function automatic logic [7:0] active_high(input logic [7:0] raw);
    return ~raw;
  endfunction

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_GAP;
      gap_q    <= '0;
      bit_q    <= '0;
      sr_q     <= 16'hFFFF;
      clk_q    <= 1'b0;
      load_n_q <= 1'b1;
      joy1_q   <= '0;
      joy2_q   <= '0;
      stb_q    <= 1'b0;
`ifdef JOY_SERIAL_DEBOUNCE_EN
      prev_q   <= 16'hFFFF;
`endif
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      clk_q    <= clk_d;
      load_n_q <= load_n_d;
      joy1_q   <= joy1_d;
      joy2_q   <= joy2_d;
      stb_q    <= stb_d;
`ifdef JOY_SERIAL_DEBOUNCE_EN
      prev_q   <= prev_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    bit_d    = bit_q;
    sr_d     = sr_q;
    clk_d    = clk_q;
    load_n_d = load_n_q;
    joy1_d   = joy1_q;
    joy2_d   = joy2_q;
    stb_d    = 1'b0;
`ifdef JOY_SERIAL_DEBOUNCE_EN
    prev_d   = prev_q;
`endif
    if (tick) begin
      case (state_q)
        S_GAP: begin
          // With ENABLE low the count parks at its last value so restart takes one tick.
          if (gap_q == GAP_LAST) begin
            if (ENABLE) begin
              gap_d    = '0;
              load_n_d = 1'b0;
              state_d  = S_LOAD;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        S_LOAD: begin
          load_n_d = 1'b1;
          bit_d    = '0;
          state_d  = S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          sr_d = {sr_q[14:0], JOY_DATA};
          if (bit_q == 4'd15) begin
            state_d = S_DONE;
          end else begin
            clk_d   = 1'b1;
            state_d = S_SHIFT_HI;
          end
        end
        S_SHIFT_HI: begin
          clk_d   = 1'b0;
          bit_d   = bit_q + 4'd1;
          state_d = S_SHIFT_LO;
        end
        S_DONE: begin
`ifdef JOY_SERIAL_DEBOUNCE_EN
          if (sr_q == prev_q) begin
            joy1_d = active_high(sr_q[15:8]);
            joy2_d = active_high(sr_q[7:0]);
          end
          prev_d = sr_q;
`else
          joy1_d = active_high(sr_q[15:8]);
          joy2_d = active_high(sr_q[7:0]);
`endif
          stb_d   = 1'b1;
          state_d = S_GAP;
        end
        default: begin
          state_d = S_GAP;
        end
      endcase
    end
  end

  assign JOY_CLK    = clk_q;
  assign JOY_LOAD_N = load_n_q;
  assign JOY1       = joy1_q;
  assign JOY2       = joy2_q;
  assign FRAME_STB  = stb_q;

endmodule
